// File: rtl/mem_wb_stage_pkg.sv
// Shared ISA definitions and writeback bundle for execute/memory/writeback and hazard logic.
package mem_wb_stage_pkg;
  localparam int ISA_XLEN = 32;

  localparam logic [7:0] ALU_OPERATIONS_LB  = 8'h20;
  localparam logic [7:0] ALU_OPERATIONS_LH  = 8'h21;
  localparam logic [7:0] ALU_OPERATIONS_LW  = 8'h22;
  localparam logic [7:0] ALU_OPERATIONS_LBU = 8'h23;
  localparam logic [7:0] ALU_OPERATIONS_LHU = 8'h24;

  typedef struct packed {
    logic                valid;
    logic                wr_en;
    logic [4:0]          rd;
    logic [ISA_XLEN-1:0] data;
  } wb_bundle_t;
endpackage

// File: rtl/mem_wb_stage_load_formatter.sv
// Combinational load lane extraction and sign/zero extension with misalignment detection.
module load_formatter
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN = ISA_XLEN
) (
  input  logic [7:0]      operation,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b     = word[{offset, 3'b000} +: 8];
    lane_h     = offset[1] ? word[31:16] : word[15:0];
    data       = word;
    misaligned = 1'b0;
    case (operation)
      ALU_OPERATIONS_LB:  data = {{(XLEN-8){lane_b[7]}}, lane_b};
      ALU_OPERATIONS_LBU: data = {{(XLEN-8){1'b0}}, lane_b};
      ALU_OPERATIONS_LH: begin
        data       = {{(XLEN-16){lane_h[15]}}, lane_h};
        misaligned = offset[0];
      end
      ALU_OPERATIONS_LHU: begin
        data       = {{(XLEN-16){1'b0}}, lane_h};
        misaligned = offset[0];
      end
      // LW and any unrecognised code on a load behave as a full-word load
      default: misaligned = (offset != 2'b00);
    endcase
  end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: formats loads, registers the writeback bundle, counts retirement.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN  = ISA_XLEN,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             mem_rd_en,
  input  logic             reg_wr_en,
  input  logic [7:0]       alu_operation,
  input  logic [4:0]       rd_addr,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  memory_data,
  output logic             wb_valid,
  output logic             wb_reg_wr_en,
  output logic [4:0]       wb_rd_addr,
  output logic [XLEN-1:0]  wb_data,
  output logic             load_misaligned,
  output logic [CNT_W-1:0] instret
);
  wb_bundle_t      wb_q;
  logic [XLEN-1:0] fmt_data;
  logic            fmt_misaligned;
  logic            misaligned;
  logic [XLEN-1:0] next_data;

  load_formatter #(.XLEN(XLEN)) u_load_formatter (
    .operation  (alu_operation),
    .offset     (alu_result[1:0]),
    .word       (memory_data),
    .data       (fmt_data),
    .misaligned (fmt_misaligned)
  );

  assign misaligned = mem_rd_en & fmt_misaligned;
  assign next_data  = mem_rd_en ? (misaligned ? '0 : fmt_data) : alu_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q            <= '0;
      load_misaligned <= 1'b0;
      instret         <= '0;
    end else if (flush) begin
      wb_q            <= '0;
      load_misaligned <= 1'b0;
    end else if (stall) begin
      // held slot must not re-raise the exception pulse
      load_misaligned <= 1'b0;
    end else begin
      wb_q.valid      <= in_valid;
      wb_q.wr_en      <= in_valid & reg_wr_en & (rd_addr != 5'd0) & ~misaligned;
      wb_q.rd         <= rd_addr;
      wb_q.data       <= next_data;
      load_misaligned <= in_valid & misaligned;
      if (in_valid) begin
        instret <= instret + 1'b1;
      end
    end
  end

  assign wb_valid     = wb_q.valid;
  assign wb_reg_wr_en = wb_q.wr_en;
  assign wb_rd_addr   = wb_q.rd;
  assign wb_data      = wb_q.data;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, in_valid = 1'b0, mem_rd_en = 1'b0, reg_wr_en = 1'b0;
  logic [7:0]  alu_operation = 8'h00;
  logic [4:0]  rd_addr = 5'd0;
  logic [31:0] alu_result = 32'd0, memory_data = 32'd0;
  logic        wb_valid, wb_reg_wr_en, load_misaligned;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic [63:0] instret;

  int total = 0;
  int bad   = 0;

  // model state
  logic        m_valid, m_wr, m_mis;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [63:0] m_cnt;

  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_OTHER = 8'h5A;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .mem_rd_en(mem_rd_en), .reg_wr_en(reg_wr_en), .alu_operation(alu_operation),
    .rd_addr(rd_addr), .alu_result(alu_result), .memory_data(memory_data),
    .wb_valid(wb_valid), .wb_reg_wr_en(wb_reg_wr_en), .wb_rd_addr(wb_rd_addr),
    .wb_data(wb_data), .load_misaligned(load_misaligned), .instret(instret)
  );

  always #5 clk = ~clk;

  // Load result from the ISA rules using plain shifts/arithmetic.
  function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] w, output bit mis);
    longint unsigned off, b, h;
    off = addr % 4;
    b   = (w >> (8 * off)) % 256;
    h   = (w >> (8 * off)) % 65536;
    mis = 0;
    if (op == ALU_OPERATIONS_LB)  return (b >= 128) ? 32'(b + 64'hFFFFFF00) : 32'(b);
    if (op == ALU_OPERATIONS_LBU) return 32'(b);
    if (op == ALU_OPERATIONS_LH || op == ALU_OPERATIONS_LHU) begin
      mis = (off % 2) != 0;
      if (op == ALU_OPERATIONS_LH && h >= 32768) return 32'(h + 64'hFFFF0000);
      return 32'(h);
    end
    mis = (off != 0);
    return w;
  endfunction

  function automatic void model_step();
    bit          mis;
    logic [31:0] f;
    if (rst) begin
      {m_valid, m_wr, m_mis, m_rd, m_data} = '0;
      m_cnt = 0;
    end else if (flush) begin
      {m_valid, m_wr, m_mis, m_rd, m_data} = '0;
    end else if (stall) begin
      m_mis = 1'b0;
    end else begin
      f       = model_load(alu_operation, alu_result, memory_data, mis);
      mis     = mis && mem_rd_en;
      m_valid = in_valid;
      m_wr    = in_valid && reg_wr_en && (rd_addr != 0) && !mis;
      m_rd    = rd_addr;
      m_data  = mem_rd_en ? (mis ? 32'd0 : f) : alu_result;
      m_mis   = in_valid && mis;
      if (in_valid) m_cnt = m_cnt + 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic we, input logic [7:0] op,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem);
    in_valid = v; mem_rd_en = ld; reg_wr_en = we; alu_operation = op;
    rd_addr = rd; alu_result = alu; memory_data = mem;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, OP_ADD, 5'(i + 1), 32'(100 + i), 32'd0);
      tick();
    end
    stall = 1'b1;
    #2 rst = 1'b1;
    {m_valid, m_wr, m_mis, m_rd, m_data} = '0;
    m_cnt = 0;
    #1;
    total++;
    if ({wb_valid, wb_reg_wr_en, load_misaligned, wb_rd_addr, wb_data} !== 40'd0 || instret !== 64'd0) begin
      bad++;
      $display("FAIL reset_async: outs=%b/%b/%b rd=%0d data=%h instret=%0d, required all zero",
               wb_valid, wb_reg_wr_en, load_misaligned, wb_rd_addr, wb_data, instret);
    end
    tick(); tick(); tick();
    total++;
    if ({wb_valid, wb_reg_wr_en, load_misaligned, wb_rd_addr, wb_data} !== 40'd0 || instret !== 64'd0) begin
      bad++;
      $display("FAIL reset_held: data=%h valid=%b instret=%0d, required zeros", wb_data, wb_valid, instret);
    end
    rst = 1'b0; stall = 1'b0;
    drive(1'b1, 1'b0, 1'b1, OP_ADD, 5'd5, 32'h1234, 32'd0);
    tick();
    total++;
    if (wb_data !== 32'h1234 || wb_reg_wr_en !== 1'b1 || wb_rd_addr !== 5'd5 || instret !== 64'd1) begin
      bad++;
      $display("FAIL reset_first_op: data=%h we=%b rd=%0d instret=%0d, required 1234/1/5/1",
               wb_data, wb_reg_wr_en, wb_rd_addr, instret);
    end
  endtask

  task automatic test_byte_loads();
    logic [31:0] exp_lb [4];
    exp_lb = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};
    for (int off = 0; off < 4; off++) begin
      drive(1'b1, 1'b1, 1'b1, ALU_OPERATIONS_LB, 5'd10, 32'h200 + 32'(off), 32'h80FF7F01);
      tick();
      total++;
      if (wb_data !== exp_lb[off] || wb_reg_wr_en !== 1'b1 || load_misaligned !== 1'b0) begin
        bad++;
        $display("FAIL lb_off%0d: data=%h we=%b mis=%b, required %h/1/0", off, wb_data,
                 wb_reg_wr_en, load_misaligned, exp_lb[off]);
      end
    end
    drive(1'b1, 1'b1, 1'b1, ALU_OPERATIONS_LBU, 5'd11, 32'h203, 32'h80FF7F01);
    tick();
    total++;
    if (wb_data !== 32'h00000080) begin
      bad++;
      $display("FAIL lbu_off3: data=%h, required 00000080", wb_data);
    end
  endtask

  task automatic test_half_word_loads();
    logic [7:0]  ops  [3];
    logic [31:0] adrs [3];
    logic [31:0] exps [3];
    ops  = '{ALU_OPERATIONS_LH, ALU_OPERATIONS_LHU, ALU_OPERATIONS_LW};
    adrs = '{32'h300, 32'h302, 32'h300};
    exps = '{32'hFFFFF00F, 32'h00008001, 32'h8001F00F};
    // back-to-back: one result per cycle with no bubble
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, ops[i], 5'(12 + i), adrs[i], 32'h8001F00F);
      tick();
      total++;
      if (wb_data !== exps[i] || wb_valid !== 1'b1 || wb_rd_addr !== 5'(12 + i) || instret !== m_cnt) begin
        bad++;
        $display("FAIL half_word_%0d: data=%h valid=%b rd=%0d instret=%0d, required %h/1/%0d/%0d",
                 i, wb_data, wb_valid, wb_rd_addr, instret, exps[i], 12 + i, m_cnt);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [63:0] cnt_before;
    cnt_before = m_cnt;
    drive(1'b1, 1'b1, 1'b1, ALU_OPERATIONS_LW, 5'd7, 32'h102, 32'hDEADBEEF);
    tick();
    total++;
    if (wb_valid !== 1'b1 || wb_reg_wr_en !== 1'b0 || load_misaligned !== 1'b1 ||
        wb_data !== 32'd0 || instret !== cnt_before + 1) begin
      bad++;
      $display("FAIL misaligned_lw: v=%b we=%b mis=%b data=%h instret=%0d, required 1/0/1/0/%0d",
               wb_valid, wb_reg_wr_en, load_misaligned, wb_data, instret, cnt_before + 1);
    end
    stall = 1'b1;
    tick();
    total++;
    if (load_misaligned !== 1'b0 || wb_valid !== 1'b1 || instret !== cnt_before + 1) begin
      bad++;
      $display("FAIL misaligned_pulse: mis=%b v=%b instret=%0d, required 0/1/%0d",
               load_misaligned, wb_valid, instret, cnt_before + 1);
    end
    stall = 1'b0;
  endtask

  task automatic test_x0_flush();
    logic [63:0] cnt_before;
    drive(1'b1, 1'b0, 1'b1, OP_ADD, 5'd0, 32'h55, 32'd0);
    tick();
    total++;
    if (wb_reg_wr_en !== 1'b0 || wb_valid !== 1'b1) begin
      bad++;
      $display("FAIL x0_write: we=%b v=%b, required 0/1", wb_reg_wr_en, wb_valid);
    end
    cnt_before = m_cnt;
    drive(1'b1, 1'b0, 1'b1, OP_ADD, 5'd9, 32'h77, 32'd0);
    flush = 1'b1; stall = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    total++;
    if (wb_valid !== 1'b0 || wb_reg_wr_en !== 1'b0 || wb_data !== 32'd0 ||
        wb_rd_addr !== 5'd0 || instret !== cnt_before) begin
      bad++;
      $display("FAIL flush_over_stall: v=%b we=%b data=%h rd=%0d instret=%0d, required 0/0/0/0/%0d",
               wb_valid, wb_reg_wr_en, wb_data, wb_rd_addr, instret, cnt_before);
    end
  endtask

  task automatic test_stall();
    logic [63:0] cnt_hold;
    drive(1'b1, 1'b1, 1'b1, ALU_OPERATIONS_LH, 5'd3, 32'h400, 32'h8001F00F);
    tick();
    cnt_hold = m_cnt;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'($urandom), 1'b1, OP_ADD, 5'($urandom), $urandom, $urandom);
      tick();
      total++;
      if (wb_data !== 32'hFFFFF00F || wb_rd_addr !== 5'd3 || wb_valid !== 1'b1 ||
          wb_reg_wr_en !== 1'b1 || instret !== cnt_hold) begin
        bad++;
        $display("FAIL stall_hold_%0d: data=%h rd=%0d v=%b we=%b instret=%0d, required FFFFF00F/3/1/1/%0d",
                 i, wb_data, wb_rd_addr, wb_valid, wb_reg_wr_en, instret, cnt_hold);
      end
    end
    stall = 1'b0;
    drive(1'b1, 1'b0, 1'b1, OP_ADD, 5'd9, 32'hABCD, 32'd0);
    tick();
    total++;
    if (wb_data !== 32'hABCD || wb_rd_addr !== 5'd9 || instret !== cnt_hold + 1) begin
      bad++;
      $display("FAIL stall_release: data=%h rd=%0d instret=%0d, required ABCD/9/%0d",
               wb_data, wb_rd_addr, instret, cnt_hold + 1);
    end
  endtask

  task automatic test_random();
    logic [7:0] ops [7];
    ops = '{ALU_OPERATIONS_LB, ALU_OPERATIONS_LH, ALU_OPERATIONS_LW, ALU_OPERATIONS_LBU,
            ALU_OPERATIONS_LHU, OP_ADD, OP_OTHER};
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 4) != 0),
            ops[$urandom_range(0, 6)], 5'($urandom), $urandom, $urandom);
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 11) == 0);
      tick();
      total++;
      if ({wb_valid, wb_reg_wr_en, load_misaligned} !== {m_valid, m_wr, m_mis} || instret !== m_cnt) begin
        bad++;
        $display("FAIL rand_ctrl cyc %0d: v/we/mis=%b%b%b instret=%0d, required %b%b%b %0d",
                 i, wb_valid, wb_reg_wr_en, load_misaligned, instret, m_valid, m_wr, m_mis, m_cnt);
      end
      if (m_valid) begin
        total++;
        if (wb_rd_addr !== m_rd || wb_data !== m_data) begin
          bad++;
          $display("FAIL rand_data cyc %0d: rd=%0d data=%h, required rd=%0d data=%h",
                   i, wb_rd_addr, wb_data, m_rd, m_data);
        end
      end
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    {m_valid, m_wr, m_mis, m_rd, m_data} = '0;
    m_cnt = 0;
    #1;
    total++;
    if ({wb_valid, wb_reg_wr_en, load_misaligned, wb_data} !== 35'd0 || instret !== 64'd0) begin
      bad++;
      $display("FAIL power_on_reset: v=%b data=%h instret=%0d, required zeros", wb_valid, wb_data, instret);
    end
    tick();
    test_reset();
    test_byte_loads();
    test_half_word_loads();
    test_misaligned();
    test_x0_flush();
    test_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Pipeline register and load-formatting stage between the memory stage and register-file writeback. Captures the memory stage's word read data, ALU result and destination info each cycle, extracts and sign/zero-extends the addressed byte/halfword for loads, and presents a registered writeback bundle to the register file and forwarding unit. Also counts retired instructions and flags misaligned loads.

## Interface
Parameters:
- XLEN, 32, datapath width
- CNT_W, 64, retired-instruction counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold current writeback register contents
- flush  in  1  squash incoming instruction
- in_valid  in  1  memory-stage slot holds a real instruction
- mem_rd_en  in  1  instruction is a load
- reg_wr_en  in  1  instruction writes rd
- alu_operation  in  8  operation code (shared ALU_OPERATIONS_* encodings)
- rd_addr  in  5  destination register
- alu_result  in  XLEN  ALU result / effective address
- memory_data  in  XLEN  word read by memory stage (word containing the address)
- wb_valid  out  1  writeback slot valid
- wb_reg_wr_en  out  1  register-file write enable
- wb_rd_addr  out  5  register-file write address
- wb_data  out  XLEN  register-file write data
- load_misaligned  out  1  one-cycle exception pulse
- instret  out  CNT_W  retired-instruction count

## Operation
- Next write data: load (mem_rd_en=1) -> formatted memory_data; else alu_result.
- Byte offset = alu_result[1:0]. LB/LBU: lane = offset, bits [8*off+7:8*off]; sign- (LB) or zero-extend (LBU) to XLEN.
- LH/LHU: offset 0 -> bits [15:0], offset 2 -> bits [31:16]; offsets 1,3 misaligned.
- LW: offset 0 only; any other offset misaligned.
- Load with mem_rd_en=1 and an operation code not a load encoding: treated as LW.
- Misaligned load with in_valid=1: captured slot has wb_reg_wr_en=0, wb_data=0, wb_valid=1; load_misaligned=1 for that cycle.
- wb_reg_wr_en = captured in_valid & reg_wr_en & (rd_addr != 0) & ~misaligned. Writes to x0 never asserted.
- instret increments by 1 on each cycle a new slot with in_valid=1 is captured (misaligned included); wraps modulo 2^CNT_W silently.

## Timing
- Latency: 1 cycle; inputs sampled at rising clk, outputs registered.
- Priority per edge: rst > flush > stall > capture.
- flush=1: wb_valid, wb_reg_wr_en, load_misaligned cleared to 0; wb_rd_addr, wb_data cleared to 0; instret unchanged. flush overrides a simultaneous stall.
- stall=1 (flush=0): all wb_* outputs hold; load_misaligned forced 0 (pulse never repeats while held); instret unchanged.
- in_valid=0 capture: wb_valid=0, wb_reg_wr_en=0, load_misaligned=0; wb_data/wb_rd_addr still load (don't-care for consumers).
- Reset (asserted any time, incl. mid-stall): every output 0 immediately, instret=0; first capture on the first rising edge after rst deasserts.
- Back-to-back valid instructions retire one per cycle with no bubbles.

## Structure
- Load encodings (ALU_OPERATIONS_LB/LH/LW/LBU/LHU) and XLEN belong in the shared ISA definitions header already used by execute/memory stages; no local duplicates.
- Writeback bundle typedef (valid, wr_en, rd, data) goes in the shared package for reuse by forwarding/hazard units.
- One sub-module: load_formatter (combinational: operation, offset, word -> formatted data, misaligned flag). Top holds registers, priority logic and counter.

## Test plan
- Reset: hold rst 3 cycles mid-traffic -> all outputs 0, instret=0; release, one ALU op (alu_result=0x1234, rd=5) -> next cycle wb_data=0x1234, wb_reg_wr_en=1, instret=1.
- Byte loads: memory_data=0x80FF7F01, LB offsets 0..3 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; LBU offset 3 -> 0x00000080.
- Half/word loads: memory_data=0x8001F00F, LH off0 -> 0xFFFFF00F, LHU off2 -> 0x00008001, LW off0 -> 0x8001F00F.
- Misaligned: LW alu_result=0x102, rd=7 -> wb_valid=1, wb_reg_wr_en=0, load_misaligned=1 for exactly one cycle even if stall then asserts.
- x0 and flush: ALU op rd=0 -> wb_reg_wr_en=0; valid op with flush=1 and stall=1 same edge -> wb_valid=0, instret unchanged.
- Stall hold: capture LH result, stall 4 cycles with changing inputs -> wb_* stable, instret stable; release -> next input captured on following edge.
